// File: rtl/muldiv_seq_ctrl_pkg.sv
// Shared encodings for the EXE-stage multiply/divide sequencer.
package muldiv_seq_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE    = 6'h00;

    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2,
        MD_DONE = 2'd3
    } md_state_e;

    // True for the funct codes that run the 32-step iteration.
    function automatic logic is_iter_funct(input logic [5:0] f);
        return (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
               (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
    endfunction

endpackage

// File: rtl/md_iter_step.sv
// One iteration of shift-add multiply or restoring divide on a 2*XLEN accumulator.
// MUL: acc = {partial product, remaining multiplier bits}, shifts right.
// DIV: acc = {partial remainder, remaining dividend / quotient bits}, shifts left.
module md_iter_step
    import muldiv_seq_ctrl_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic              is_div_i,
    input  logic [XLEN-1:0]   opb_i,
    input  logic [2*XLEN-1:0] acc_i,
    output logic [2*XLEN-1:0] acc_o
);

    logic [XLEN:0]   add_sum;
    logic            rem_ge;
    logic [XLEN-1:0] rem_sub;

    // Single combinational step; a zero divisor always subtracts, which yields the
    // all-ones quotient and the untouched dividend as remainder.
    always_comb begin
        add_sum = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opb_i} : '0);
        rem_ge  = (acc_i[2*XLEN-1:XLEN-1] >= {1'b0, opb_i});
        rem_sub = acc_i[2*XLEN-2:XLEN-1] - opb_i;
        acc_o   = '0;
        if (is_div_i) begin
            if (rem_ge) begin
                acc_o = {rem_sub, acc_i[XLEN-2:0], 1'b1};
            end else begin
                acc_o = {acc_i[2*XLEN-2:0], 1'b0};
            end
        end else begin
            acc_o = {add_sum, acc_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq_ctrl.sv
// EXE-stage multiply/divide sequencer: FSM, step counter, operand latches,
// sign fix-up and the HI/LO architectural registers.
module muldiv_seq_ctrl
    import muldiv_seq_ctrl_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            EXE_Valid,
    input  logic [5:0]      EXE_OP,
    input  logic [5:0]      EXE_Funct,
    input  logic            EXE_Kill,
    input  logic [XLEN-1:0] rs_data,
    input  logic [XLEN-1:0] rt_data,
    output logic            MD_Stall,
    output logic            MD_Busy,
    output logic [XLEN-1:0] HI,
    output logic [XLEN-1:0] LO
);

    localparam int unsigned CNT_W = $clog2(XLEN) + 1;

    md_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic              div_q, div_d;
    logic              neg_lo_q, neg_lo_d;
    logic              neg_hi_q, neg_hi_d;
    logic              busy_q, busy_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;

    logic              issue;
    logic              start;
    logic              signed_op;
    logic              div_op;
    logic              rs_neg;
    logic              rt_neg;
    logic [XLEN-1:0]   rs_mag;
    logic [XLEN-1:0]   rt_mag;
    logic [2*XLEN-1:0] step_acc;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;

    md_iter_step #(
        .XLEN (XLEN)
    ) u_step (
        .is_div_i (state_q == MD_DIV),
        .opb_i    (opb_q),
        .acc_i    (acc_q),
        .acc_o    (step_acc)
    );

    // Decode of the EXE instruction, operand magnitudes and DONE-cycle sign fix-up.
    always_comb begin
        issue     = EXE_Valid && !EXE_Kill && (EXE_OP == OP_RTYPE);
        start     = issue && is_iter_funct(EXE_Funct) && (state_q == MD_IDLE);
        signed_op = !EXE_Funct[0];
        div_op    = EXE_Funct[1];
        rs_neg    = signed_op && rs_data[XLEN-1];
        rt_neg    = signed_op && rt_data[XLEN-1];
        rs_mag    = rs_neg ? (~rs_data + 1'b1) : rs_data;
        rt_mag    = rt_neg ? (~rt_data + 1'b1) : rt_data;
        prod_fix  = neg_lo_q ? (~acc_q + 1'b1) : acc_q;
        quo_fix   = neg_lo_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
        rem_fix   = neg_hi_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
    end

    // Next-state, datapath-load and stall logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        div_d    = div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        MD_Stall = 1'b0;

        unique case (state_q)
            MD_IDLE: begin
                if (start) begin
                    MD_Stall = 1'b1;
                    state_d  = div_op ? MD_DIV : MD_MUL;
                    cnt_d    = '0;
                    div_d    = div_op;
                    neg_lo_d = rs_neg ^ rt_neg;
                    neg_hi_d = rs_neg;
                    if (div_op) begin
                        acc_d = {{XLEN{1'b0}}, rs_mag};
                        opb_d = rt_mag;
                    end else begin
                        acc_d = {{XLEN{1'b0}}, rt_mag};
                        opb_d = rs_mag;
                    end
                end else if (issue && (EXE_Funct == FUNCT_MTHI)) begin
                    hi_d = rs_data;
                end else if (issue && (EXE_Funct == FUNCT_MTLO)) begin
                    lo_d = rs_data;
                end
            end
            MD_MUL, MD_DIV: begin
                MD_Stall = 1'b1;
                acc_d    = step_acc;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(XLEN - 1)) begin
                    state_d = MD_DONE;
                end
            end
            MD_DONE: begin
                state_d = MD_IDLE;
                cnt_d   = '0;
                if (div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*XLEN-1:XLEN];
                    lo_d = prod_fix[XLEN-1:0];
                end
            end
            default: state_d = MD_IDLE;
        endcase

        // Kill overrides everything above, including a pending DONE write-back.
        if (EXE_Kill) begin
            state_d = MD_IDLE;
            cnt_d   = '0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end

        busy_d = (state_d == MD_MUL) || (state_d == MD_DIV);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= MD_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            div_q    <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            busy_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            div_q    <= div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            busy_q   <= busy_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign MD_Busy = busy_q;
    assign HI      = hi_q;
    assign LO      = lo_q;

endmodule

// File: doc/muldiv_seq_ctrl.md
# muldiv_seq_ctrl

Sequencer for the iterative multiply/divide unit in the EXE stage, owning the HI/LO registers. It decodes MULT/MULTU/DIV/DIVU/MTHI/MTLO in EXE and runs a 32-step shift-add multiply or restoring divide. It holds the front of the pipeline with `MD_Stall` until the result is ready. It sits beside the load-use and branch hazard logic; the pipeline ORs `MD_Stall` into the existing PC/IF write-enable and stage-hold terms.

## Interface

- `XLEN`, 32, operand/HI/LO width; the step counter width is clog2(XLEN)+1.
- `clk`  in  1  pipeline clock; all state changes on the rising edge.
- `rst`  in  1  reset: synchronous, active-low.
- `EXE_Valid`  in  1  EXE holds a real instruction (not a bubble).
- `EXE_OP`  in  6  opcode of the EXE instruction.
- `EXE_Funct`  in  6  funct field of the EXE instruction.
- `EXE_Kill`  in  1  synchronous abort of the EXE instruction.
- `rs_data`  in  XLEN  forwarded rs operand (dividend / multiplicand / MTHI-MTLO source).
- `rt_data`  in  XLEN  forwarded rt operand (divisor / multiplier).
- `MD_Stall`  out  1  hold PC, IF/ID, ID/EXE; insert bubble into EXE/MEM.
- `MD_Busy`  out  1  iteration in progress (MUL or DIV state).
- `HI`  out  XLEN  HI register.
- `LO`  out  XLEN  LO register.

## Operation

- Start condition: `EXE_Valid` & `EXE_OP`==R-type & funct ∈ {MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B} & state==IDLE & !`EXE_Kill`.
- States: IDLE, MUL, DIV, DONE.
  - IDLE→MUL/DIV on start.
  - MUL/DIV→DONE after step 32.
  - DONE→IDLE always.
  - Any state→IDLE on `EXE_Kill` or reset.
- On start, latch the operands and the signed flag.
  - Signed ops latch |rs| and |rt|, plus the result signs: product sign = rs[31]^rt[31]; quotient sign = rs[31]^rt[31]; remainder sign = rs[31].
  - Unsigned ops latch the operands unchanged, with both signs cleared.
- MUL step: one shift-add per cycle into a 64-bit accumulator.
- DIV step: one restoring subtract per cycle. Quotient bit = 1 iff partial remainder ≥ divisor.
- DONE: apply the negations and write {HI,LO} at the end of the DONE cycle.
  - MUL: {HI,LO} = 64-bit product.
  - DIV: LO = quotient, HI = remainder.
- Divide by zero uses the same algorithm, no special case.
  - DIVU: LO=0xFFFFFFFF, HI=rs.
  - DIV, rs≥0: LO=0xFFFFFFFF, HI=rs.
  - DIV, rs<0: LO=0x00000001, HI=rs.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- MTHI/MTLO: in IDLE with `EXE_Valid` & !`EXE_Kill`, write `rs_data` to HI/LO at the end of the cycle. No stall.
- MFHI/MFLO need no handling here; the EXE mux reads `HI`/`LO` directly. Their correctness follows from the stall.
- DONE ignores a new start; the same MULT/DIV is still in EXE during the DONE cycle.
- `EXE_Kill` during MUL/DIV/DONE: go to IDLE, leave HI/LO unchanged, drop the result.

## Timing

- Reset values: state=IDLE, counter=0, HI=0, LO=0, `MD_Stall`=0, `MD_Busy`=0.
- `MD_Stall` = (IDLE & start) | MUL | DIV. It is combinational from the EXE inputs in the start cycle.
- `MD_Busy` = MUL | DIV, registered.
- Latency, start at cycle 0:
  - Cycle 0: stall=1; operands latched at the end of the cycle.
  - Cycles 1–32: one step per cycle, stall=1.
  - Cycle 33: DONE, stall=0, so the instruction leaves EXE at the end of the cycle. HI/LO update at the same edge.
- Stall duration is exactly 33 cycles for every mult/div, including divide by zero.
- An MFHI/MFLO immediately behind the op reaches EXE in cycle 34 and sees the new value.
- Kill in cycle k∈[1,33]: state=IDLE and stall=0 from cycle k+1.
- Kill in cycle 0: no start and no stall.
- Reset mid-operation: from the next cycle, all reset values apply.
- Back-to-back ops: a second MULT entering EXE in cycle 34 starts normally in that cycle.

## Structure

- Add to `Ctrl_encoding_def.v`:
  - funct defines `FUNCT_MULT`, `FUNCT_MULTU`, `FUNCT_DIV`, `FUNCT_DIVU`, `FUNCT_MTHI`, `FUNCT_MTLO`, `FUNCT_MFHI`, `FUNCT_MFLO`;
  - 2-bit state encodings `MD_IDLE`, `MD_MUL`, `MD_DIV`, `MD_DONE`.
- One sub-module, `md_iter_step`: combinational single-step shift-add / restoring-subtract datapath, selected by a mul/div input.
- `muldiv_seq_ctrl` keeps the FSM, counter, operand/sign latches, sign fix-up and HI/LO.

## Test plan

- MULT rs=0xFFFFFFFD (−3), rt=7 → stall high exactly cycles 0–32; HI=0xFFFFFFFF, LO=0xFFFFFFEB after cycle 33.
- MULTU 0xFFFFFFFF×0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001; the MFLO in cycle 34 reads 0x00000001.
- DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU 7/0 → LO=0xFFFFFFFF, HI=7, stall still 33 cycles.
- MTHI 0x12345678, then MULT with `EXE_Kill` at cycle 10 → stall low from cycle 11, HI stays 0x12345678.
- MULT, then `rst`=0 at cycle 5 → stall low from cycle 6, HI=LO=0.
